// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Reads are registered (one cycle latency); optional same-cycle forwarding
// makes a read observe the state the array holds after the current edge.
module regfile_mp #(
    parameter int DEPTH    = 32,
    parameter int WIDTH    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NWR-1:0]         we,
    input  logic [NWR*AW-1:0]      wr_addr,
    input  logic [NWR*WIDTH-1:0]   wr_din,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*WIDTH-1:0]   rd_dout,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   busy_set,
    input  logic [AW-1:0]          busy_addr,
    output logic [DEPTH-1:0]       busy_vec
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0]     wr_hit;
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic [NRD*WIDTH-1:0] rd_dout_q;
    logic [NRD*WIDTH-1:0] rd_dout_d;
    logic [NRD-1:0]       rd_busy_q;
    logic [NRD-1:0]       rd_busy_d;
    logic [AW-1:0]        ra [NRD];

    // Resolve write ports per register; ascending port order lets the highest port win.
    // Only in-range registers are scanned, so out-of-range write addresses never match.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            mem_d[r]  = mem_q[r];
            wr_hit[r] = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && (wr_addr[p*AW +: AW] == AW'(r)) && !(ZERO_REG && (r == 0))) begin
                    mem_d[r]  = wr_din[p*WIDTH +: WIDTH];
                    wr_hit[r] = 1'b1;
                end
            end
        end
    end

    // Scoreboard next state: a write retires the pending producer, a new busy_set re-arms it.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            busy_d[r] = (busy_q[r] & ~wr_hit[r])
                      | (busy_set && (busy_addr == AW'(r)) && !(ZERO_REG && (r == 0)));
        end
    end

    // Read muxes: forwarded ports see the post-edge array, others the current one.
    always_comb begin
        rd_dout_d = '0;
        rd_busy_d = '0;
        for (int q = 0; q < NRD; q++) begin
            ra[q] = rd_addr[q*AW +: AW];
            if (32'(ra[q]) < DEPTH) begin
                if (BYPASS) begin
                    rd_dout_d[q*WIDTH +: WIDTH] = mem_d[ra[q]];
                    rd_busy_d[q]                = busy_d[ra[q]];
                end else begin
                    rd_dout_d[q*WIDTH +: WIDTH] = mem_q[ra[q]];
                    rd_busy_d[q]                = busy_q[ra[q]];
                end
            end
        end
    end

    // All architectural state and read registers; reset wipes everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q    <= '0;
            rd_dout_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q    <= busy_d;
            rd_dout_q <= rd_dout_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_dout  = rd_dout_q;
    assign rd_busy  = rd_busy_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against an array-level reference model.
module tb_regfile_mp;

    localparam int DEPTH    = 24;
    localparam int WIDTH    = 32;
    localparam int NRD      = 3;
    localparam int NWR      = 2;
    localparam bit ZERO_REG = 1'b1;
    localparam bit BYPASS   = 1'b1;
    localparam int AW       = $clog2(DEPTH);

    logic                 clk;
    logic                 reset;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*WIDTH-1:0] wr_din;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*WIDTH-1:0] rd_dout;
    logic [NRD-1:0]       rd_busy;
    logic                 busy_set;
    logic [AW-1:0]        busy_addr;
    logic [DEPTH-1:0]     busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural contents and pending bits.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_busy [DEPTH];
    logic [WIDTH-1:0] exp_dout [NRD];
    bit               exp_busy [NRD];

    regfile_mp #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .NRD(NRD), .NWR(NWR),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_din(wr_din),
        .rd_addr(rd_addr), .rd_dout(rd_dout), .rd_busy(rd_busy),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [DEPTH-1:0] model_vec();
        logic [DEPTH-1:0] v;
        for (int r = 0; r < DEPTH; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Register r is writable only if it exists and is not the hardwired zero.
    function automatic bit writable(int a);
        return (a < DEPTH) && !(ZERO_REG && a == 0);
    endfunction

    task automatic model_update();
        int a;
        for (int p = 0; p < NWR; p++) begin
            a = int'(wr_addr[p*AW +: AW]);
            if (we[p] && writable(a)) begin
                m_mem[a]  = wr_din[p*WIDTH +: WIDTH];
                m_busy[a] = 1'b0;
            end
        end
        a = int'(busy_addr);
        if (busy_set && writable(a)) m_busy[a] = 1'b1;
    endtask

    task automatic model_read();
        int a;
        for (int q = 0; q < NRD; q++) begin
            a = int'(rd_addr[q*AW +: AW]);
            if (a >= DEPTH) begin
                exp_dout[q] = '0;
                exp_busy[q] = 1'b0;
            end else begin
                exp_dout[q] = m_mem[a];
                exp_busy[q] = m_busy[a];
            end
        end
    endtask

    // One clock with the currently driven inputs, then compare all outputs.
    task automatic step(string tag);
        if (!BYPASS) model_read();
        model_update();
        if (BYPASS) model_read();
        @(posedge clk);
        @(negedge clk);
        for (int q = 0; q < NRD; q++) begin
            chk($sformatf("%s_dout%0d", tag, q), 64'(rd_dout[q*WIDTH +: WIDTH]), 64'(exp_dout[q]));
            chk($sformatf("%s_busy%0d", tag, q), 64'(rd_busy[q]), 64'(exp_busy[q]));
        end
        chk($sformatf("%s_vec", tag), 64'(busy_vec), 64'(model_vec()));
    endtask

    task automatic idle_in();
        we        = '0;
        wr_addr   = '0;
        wr_din    = '0;
        busy_set  = 1'b0;
        busy_addr = '0;
    endtask

    task automatic set_wr(int p, logic en, logic [AW-1:0] a, logic [WIDTH-1:0] d);
        we[p]                   = en;
        wr_addr[p*AW +: AW]     = a;
        wr_din[p*WIDTH +: WIDTH] = d;
    endtask

    task automatic set_rd(int q, logic [AW-1:0] a);
        rd_addr[q*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, (1 << AW) - 1));
    endfunction

    initial begin
        reset = 1'b0;
        rd_addr = '0;
        idle_in();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dout", 64'(rd_dout), 64'd0);
        chk("reset_busy", 64'(rd_busy), 64'd0);
        chk("reset_vec", 64'(busy_vec), 64'd0);
        reset = 1'b1;

        // Sweep every encodable address on every port after reset.
        for (int a = 0; a < (1 << AW); a++) begin
            for (int q = 0; q < NRD; q++) set_rd(q, AW'((a + q) % (1 << AW)));
            step("sweep");
        end

        // Same-cycle write then read of register 5.
        set_wr(0, 1'b1, AW'(5), 32'hDEADBEEF);
        set_rd(0, AW'(5));
        step("bypass5");
        chk("bypass5_const", 64'(rd_dout[WIDTH-1:0]), 64'hDEADBEEF);
        idle_in();
        step("hold5");

        // Both write ports on register 7: port 1 wins.
        set_wr(0, 1'b1, AW'(7), 32'h11);
        set_wr(1, 1'b1, AW'(7), 32'h22);
        set_rd(0, AW'(7));
        set_rd(1, AW'(7));
        step("dual7");
        chk("dual7_const", 64'(rd_dout[WIDTH-1:0]), 64'h22);
        idle_in();
        step("dual7_rd");

        // Zero register ignores writes and busy_set.
        set_wr(0, 1'b1, AW'(0), 32'h1234);
        busy_set = 1'b1;
        busy_addr = AW'(0);
        set_rd(0, AW'(0));
        step("zero");
        idle_in();
        step("zero_rd");
        chk("zero_vec0", 64'(busy_vec[0]), 64'd0);

        // Scoreboard set, clear by write, set wins over simultaneous write.
        busy_set = 1'b1;
        busy_addr = AW'(3);
        set_rd(0, AW'(3));
        step("sb_set");
        idle_in();
        step("sb_hold");
        chk("sb_hold_const", 64'(rd_busy[0]), 64'd1);
        set_wr(0, 1'b1, AW'(3), 32'h3);
        step("sb_clr");
        chk("sb_clr_const", 64'(busy_vec[3]), 64'd0);
        set_wr(1, 1'b1, AW'(3), 32'h33);
        busy_set = 1'b1;
        busy_addr = AW'(3);
        step("sb_both");
        chk("sb_both_const", 64'(busy_vec[3]), 64'd1);
        idle_in();

        // Out-of-range register: write and busy_set ignored, read returns zero.
        set_wr(0, 1'b1, AW'(30), 32'hCAFE);
        busy_set = 1'b1;
        busy_addr = AW'(30);
        set_rd(2, AW'(30));
        step("oor");
        idle_in();

        // Write register 9, then reset mid-cycle.
        set_wr(0, 1'b1, AW'(9), 32'hA5);
        set_rd(0, AW'(9));
        step("r9");
        idle_in();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_dout", 64'(rd_dout), 64'd0);
        chk("midrst_busy", 64'(rd_busy), 64'd0);
        chk("midrst_vec", 64'(busy_vec), 64'd0);
        // Activity while reset is held must be discarded.
        set_wr(0, 1'b1, AW'(9), 32'h77);
        busy_set = 1'b1;
        busy_addr = AW'(9);
        @(posedge clk);
        @(negedge clk);
        chk("inrst_vec", 64'(busy_vec), 64'd0);
        reset = 1'b1;
        idle_in();
        set_rd(0, AW'(9));
        step("postrst9");

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NWR; p++)
                set_wr(p, 1'($urandom_range(0, 1)), rand_addr(), WIDTH'($urandom));
            busy_set  = ($urandom_range(0, 2) == 0);
            busy_addr = rand_addr();
            for (int q = 0; q < NRD; q++) set_rd(q, rand_addr());
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
